// File: rtl/alu_multicycle_pkg.sv
// Shared definitions for the RV64I multicycle execute-stage ALU.
// Holds the funct3 decode values, the FSM state type and the latched shift control.
package alu_multicycle_pkg;

    localparam logic [2:0] ALU_ADD_SUB = 3'b000;
    localparam logic [2:0] ALU_SLL     = 3'b001;
    localparam logic [2:0] ALU_SLT     = 3'b010;
    localparam logic [2:0] ALU_SLTU    = 3'b011;
    localparam logic [2:0] ALU_XOR     = 3'b100;
    localparam logic [2:0] ALU_SHIFTR  = 3'b101;
    localparam logic [2:0] ALU_OR      = 3'b110;
    localparam logic [2:0] ALU_AND     = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } alu_state_t;

    typedef struct packed {
        logic dir_right;
        logic arith;
        logic fill;
    } shift_ctrl_t;

    function automatic logic is_shift_op(input logic [2:0] funct3);
        return (funct3 == ALU_SLL) || (funct3 == ALU_SHIFTR);
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational shift of an XLEN-bit word by 0..SHIFT_STEP positions.
// Right shifts may back-fill with a supplied sign bit for arithmetic mode.
module alu_shift_step
    import alu_multicycle_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned AMT_W = 7
) (
    input  logic [XLEN-1:0]  i_data,
    input  logic [AMT_W-1:0] i_amount,
    input  shift_ctrl_t      i_ctrl,
    output logic [XLEN-1:0]  o_data
);

    logic [XLEN-1:0] w_ones;
    logic [XLEN-1:0] w_fill_mask;

    always_comb begin
        w_ones      = '1;
        // Bits vacated by a right shift of i_amount positions.
        w_fill_mask = ~(w_ones >> i_amount);
        if (i_ctrl.dir_right) begin
            o_data = i_data >> i_amount;
            if (i_ctrl.arith && i_ctrl.fill) begin
                o_data = o_data | w_fill_mask;
            end
        end else begin
            o_data = i_data << i_amount;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU with start/done handshake: single-cycle logic/arith/compare,
// iterative shifts of SHIFT_STEP bits per cycle, registered result and zero flag.
module alu_multicycle
    import alu_multicycle_pkg::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [3:0]      alu_funct,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic [XLEN-1:0] result,
    output logic            alu_zero,
    output logic            busy,
    output logic            done
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned CW  = SHW + 1;
    localparam logic [CW-1:0] STEP_C = CW'(SHIFT_STEP);

    alu_state_t      r_state;
    alu_state_t      w_state_nxt;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_result;
    logic [CW-1:0]   r_count;
    shift_ctrl_t     r_ctrl;
    logic            r_done;

    logic [2:0]      w_funct3;
    logic [SHW-1:0]  w_shamt;
    logic            w_accept;
    logic            w_start_shift;
    logic [XLEN-1:0] w_imm_result;
    logic [CW-1:0]   w_k;
    logic            w_last;
    logic [XLEN-1:0] w_step_out;
    shift_ctrl_t     w_ctrl_in;

    assign w_funct3      = alu_funct[2:0];
    assign w_shamt       = operand_b[SHW-1:0];
    assign w_accept      = start && (r_state == ST_IDLE);
    assign w_start_shift = w_accept && is_shift_op(w_funct3) && (w_shamt != '0);

    assign w_k    = (r_count < STEP_C) ? r_count : STEP_C;
    assign w_last = (r_state == ST_SHIFT) && (r_count == w_k);

    assign w_ctrl_in.dir_right = (w_funct3 == ALU_SHIFTR);
    assign w_ctrl_in.arith     = (w_funct3 == ALU_SHIFTR) && alu_funct[3];
    assign w_ctrl_in.fill      = operand_a[XLEN-1];

    // Single-cycle result path; a shift with shamt=0 passes operand_a through.
    always_comb begin
        w_imm_result = '0;
        case (w_funct3)
            ALU_ADD_SUB: w_imm_result = alu_funct[3] ? (operand_a - operand_b)
                                                     : (operand_a + operand_b);
            ALU_SLT:     w_imm_result = {{(XLEN-1){1'b0}},
                                         ($signed(operand_a) < $signed(operand_b))};
            ALU_SLTU:    w_imm_result = {{(XLEN-1){1'b0}}, (operand_a < operand_b)};
            ALU_XOR:     w_imm_result = operand_a ^ operand_b;
            ALU_OR:      w_imm_result = operand_a | operand_b;
            ALU_AND:     w_imm_result = operand_a & operand_b;
            default:     w_imm_result = operand_a;
        endcase
    end

    alu_shift_step #(
        .XLEN  (XLEN),
        .AMT_W (CW)
    ) u_shift_step (
        .i_data   (r_acc),
        .i_amount (w_k),
        .i_ctrl   (r_ctrl),
        .o_data   (w_step_out)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_shift) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_last)        w_state_nxt = ST_IDLE;
            default:                     w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc    <= '0;
            r_result <= '0;
            r_count  <= '0;
            r_ctrl   <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start_shift) begin
                r_acc   <= operand_a;
                r_count <= {1'b0, w_shamt};
                r_ctrl  <= w_ctrl_in;
            end else if (w_accept) begin
                r_result <= w_imm_result;
                r_done   <= 1'b1;
            end else if (r_state == ST_SHIFT) begin
                r_acc   <= w_step_out;
                r_count <= r_count - w_k;
                if (w_last) begin
                    r_result <= w_step_out;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign result   = r_result;
    assign alu_zero = (r_result == '0);
    assign busy     = (r_state == ST_SHIFT);
    assign done     = r_done;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: stimulus predicts result and done timing from an
// arithmetic reference model; a monitor compares whenever done is observed.
module tb_alu_multicycle;

    localparam int unsigned XLEN = 64;
    parameter int unsigned STEP = 1;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [3:0]      alu_funct = '0;
    logic [XLEN-1:0] operand_a = '0;
    logic [XLEN-1:0] operand_b = '0;
    logic [XLEN-1:0] result;
    logic            alu_zero;
    logic            busy;
    logic            done;

    alu_multicycle #(
        .XLEN       (XLEN),
        .SHIFT_STEP (STEP)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .alu_funct (alu_funct),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .result    (result),
        .alu_zero  (alu_zero),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_pass   = 0;
    int n_checks = 0;

    typedef struct {
        logic [63:0] res;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          free_cyc = 0;
    int          bstart   = 0;
    int          bend     = 0;
    logic [63:0] last_res = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [63:0] ref_result(input logic [3:0] f, input logic [63:0] a,
                                               input logic [63:0] b);
        int unsigned s;
        s = b[5:0];
        case (f[2:0])
            3'd0: return f[3] ? a - b : a + b;
            3'd1: return a << s;
            3'd2: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            3'd3: return (a < b) ? 64'd1 : 64'd0;
            3'd4: return a ^ b;
            3'd5: return f[3] ? 64'($signed(a) >>> s) : a >> s;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] f, input logic [63:0] b);
        int s;
        s = int'(b[5:0]);
        if ((f[2:0] == 3'd1 || f[2:0] == 3'd5) && s != 0) return 1 + (s + STEP - 1) / STEP;
        return 1;
    endfunction

    // Drive a request at a negedge; the bench decides from its own model whether it is accepted.
    task automatic issue(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                         input bit wait_free);
        exp_t e;
        int   lat;
        @(negedge clock);
        while (wait_free && cyc + 1 < free_cyc) begin
            start = 1'b0;
            @(negedge clock);
        end
        start     = 1'b1;
        alu_funct = f;
        operand_a = a;
        operand_b = b;
        if (cyc + 1 >= free_cyc) begin
            lat   = ref_latency(f, b);
            e.res = ref_result(f, a, b);
            e.due = cyc + lat;
            q.push_back(e);
            free_cyc = cyc + 1 + lat;
            if (lat > 1) begin
                bstart = cyc + 1;
                bend   = cyc + lat;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            start     = 1'b0;
            alu_funct = 4'($urandom);
            operand_a = {$urandom, $urandom};
            operand_b = {$urandom, $urandom};
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        @(negedge clock);
        start = 1'b0;
        while ((q.size() != 0 || cyc + 1 < free_cyc) && k < 3000) begin
            @(negedge clock);
            k++;
        end
        if (k >= 3000) begin
            n_checks++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clock);
        start    = 1'b0;
        reset    = 1'b1;
        q.delete();
        free_cyc = 0;
        bstart   = 0;
        bend     = 0;
        last_res = '0;
        repeat (n) @(negedge clock);
        chk("reset_result", result, 64'd0);
        chk("reset_zero", {63'd0, alu_zero}, 64'd1);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            chk("busy", {63'd0, busy}, {63'd0, (cyc >= bstart && cyc < bend)});
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    n_checks++;
                    $display("FAIL spurious_done: got done=1, expected done=0 (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.due));
                    chk("result", result, e.res);
                    chk("alu_zero", {63'd0, alu_zero}, {63'd0, (e.res == 64'd0)});
                    last_res = e.res;
                end
            end else begin
                chk("result_hold", result, last_res);
                if (q.size() > 0 && cyc > q[0].due) begin
                    n_checks++;
                    $display("FAIL missing_done: got no done by cycle %0d, expected at %0d",
                             cyc, q[0].due);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got no finish, expected finish within 60000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [63:0] ones;
        logic [63:0] msb;
        logic [3:0]  f;
        logic [63:0] a;
        logic [63:0] b;
        ones = '1;
        msb  = 64'h8000_0000_0000_0000;

        do_reset(2);

        issue(4'b0000, 64'd5, 64'd7, 1'b1);
        issue(4'b1000, 64'd5, 64'd5, 1'b1);
        issue(4'b1010, ones, 64'd1, 1'b1);
        issue(4'b1011, ones, 64'd1, 1'b1);
        issue(4'b0100, ones, 64'd1, 1'b1);
        issue(4'b1101, msb, 64'd4, 1'b1);
        issue(4'b0101, msb, 64'd4, 1'b1);
        issue(4'b0001, 64'd1, 64'h43, 1'b1);
        issue(4'b0001, 64'd1, 64'h40, 1'b1);
        drain();

        // Starts while busy are ignored; the next one lands in the done cycle.
        issue(4'b0101, 64'hF0F0_0000_1234_5678, 64'd10, 1'b1);
        issue(4'b0000, 64'd99, 64'd1, 1'b0);
        issue(4'b0111, ones, ones, 1'b0);
        idle(2);
        issue(4'b1101, msb | 64'h55, 64'd9, 1'b1);
        issue(4'b0000, 64'd3, 64'd4, 1'b1);
        issue(4'b0001, 64'd1, 64'd5, 1'b1);
        issue(4'b0110, 64'h0F, 64'hF0, 1'b1);
        drain();

        issue(4'b0001, 64'd1, 64'd40, 1'b1);
        idle(3);
        do_reset(1);
        idle(6);

        for (int i = 0; i < 300; i++) begin
            f = 4'($urandom);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) b = 64'($urandom_range(0, 63));
            if ($urandom_range(0, 5) == 0) a = ($urandom_range(0, 1) == 0) ? msb : ones;
            issue(f, a, b, ($urandom_range(0, 4) != 0));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
